// File: rtl/nios_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios_div_pkg
//  Description : Shared types and constants for the Nios II divide cell.
//  Revision    : 1.0 - initial release
// ============================================================================
package nios_div_pkg;

    // Divider sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    // Quotient returned on divide-by-zero is this bit replicated to full width
    localparam logic                  DIV_BY_ZERO_FILL = 1'b1;
    localparam logic [DIV_DATA_W-1:0] DIV_BY_ZERO_Q    = {DIV_DATA_W{DIV_BY_ZERO_FILL}};

endpackage
`default_nettype wire

// File: rtl/nios_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : nios_div_step
//  Description : One combinational restoring-division iteration on unsigned
//                magnitudes. The partial remainder is always below the
//                divisor, so it fits in DATA_W bits before and after a step.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] r_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] r_next_o,
    output logic [DATA_W-1:0] q_next_o
);

    logic [DATA_W:0]   w_r_sh;
    logic [DATA_W-1:0] w_diff;

    assign w_r_sh = {r_i, q_i[DATA_W-1]};
    // True difference is below the divisor, so the low DATA_W bits are exact
    assign w_diff = w_r_sh[DATA_W-1:0] - d_i;

    // Shift in the next dividend bit and subtract the divisor when it fits
    always_comb begin
        r_next_o = w_r_sh[DATA_W-1:0];
        q_next_o = {q_i[DATA_W-2:0], 1'b0};
        if (w_r_sh >= {1'b0, d_i}) begin
            r_next_o = w_diff;
            q_next_o = {q_i[DATA_W-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios_niosii_cpu_div_cell.sv
`default_nettype none
// ============================================================================
//  Module      : nios_niosii_cpu_div_cell
//  Description : Iterative radix-2 restoring divider for Nios II div/divu.
//                Operands are captured on a start strobe in IDLE, one
//                quotient bit is produced per CALC cycle, signs are applied
//                in FIXUP and DONE gives a one-cycle done pulse.
//                Optional feature macro: NIOS_DIV_FAST_EXIT_EN (skip CALC
//                when the divisor is zero or exceeds the dividend).
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_niosii_cpu_div_cell
    import nios_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic              M_div_abort,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quotient,
    output logic [DATA_W-1:0] M_div_remainder,
    output logic              M_div_by_zero
);

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] r_q, r_d;          // partial remainder
    logic [DATA_W-1:0] q_q, q_d;          // dividend shifting into quotient
    logic [DATA_W-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;
    logic              by_zero_q, by_zero_d;

    logic              w_neg1, w_neg2;
    logic [DATA_W-1:0] w_abs1, w_abs2;
    logic [DATA_W-1:0] w_r_next, w_q_next;

    // Magnitude of the most negative value is 2^(DATA_W-1), which still fits
    // as an unsigned DATA_W-bit number, so no bit is lost here.
    assign w_neg1 = E_div_signed & E_src1[DATA_W-1];
    assign w_neg2 = E_div_signed & E_src2[DATA_W-1];
    assign w_abs1 = w_neg1 ? (~E_src1 + 1'b1) : E_src1;
    assign w_abs2 = w_neg2 ? (~E_src2 + 1'b1) : E_src2;

    nios_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .r_i      (r_q),
        .q_i      (q_q),
        .d_i      (dvs_q),
        .r_next_o (w_r_next),
        .q_next_o (w_q_next)
    );

    // State and datapath registers; reset clears everything including outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            by_zero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            r_q         <= r_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            by_zero_q   <= by_zero_d;
        end
    end

    // Next-state and datapath; abort overrides everything and leaves outputs untouched
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        r_d         = r_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        by_zero_d   = by_zero_q;

        if (M_div_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (E_div_start) begin
                        q_d     = w_abs1;
                        dvs_d   = w_abs2;
                        r_d     = '0;
                        count_d = '0;
                        negq_d  = w_neg1 ^ w_neg2;
                        negr_d  = w_neg1;
                        dz_d    = (E_src2 == '0);
                        state_d = CALC;
`ifdef NIOS_DIV_FAST_EXIT_EN
                        // Quotient is trivially zero; remainder is the dividend
                        if ((E_src2 == '0) || (w_abs1 < w_abs2)) begin
                            q_d     = '0;
                            r_d     = w_abs1;
                            state_d = FIXUP;
                        end
`endif
                    end
                end
                CALC: begin
                    r_d     = w_r_next;
                    q_d     = w_q_next;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(DATA_W - 1)) begin
                        state_d = FIXUP;
                    end
                end
                FIXUP: begin
                    // With a zero divisor r holds |dividend|, and re-applying
                    // the dividend sign restores the raw dividend.
                    remainder_d = negr_q ? (~r_q + 1'b1) : r_q;
                    if (dz_q) begin
                        quotient_d = {DATA_W{DIV_BY_ZERO_FILL}};
                    end else begin
                        quotient_d = negq_q ? (~q_q + 1'b1) : q_q;
                    end
                    by_zero_d = dz_q;
                    state_d   = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign M_div_busy      = (state_q != IDLE);
    assign M_div_done      = (state_q == DONE) && !M_div_abort;
    assign M_div_quotient  = quotient_q;
    assign M_div_remainder = remainder_q;
    assign M_div_by_zero   = by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_niosii_cpu_div_cell.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_niosii_cpu_div_cell
//  Description : Self-checking bench for the Nios II divide cell. Expected
//                results are pushed at start and popped on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_niosii_cpu_div_cell;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] E_src1 = '0;
    logic [31:0] E_src2 = '0;
    logic        E_div_start = 1'b0;
    logic        E_div_signed = 1'b0;
    logic        M_div_abort = 1'b0;
    logic        M_div_busy;
    logic        M_div_done;
    logic [31:0] M_div_quotient;
    logic [31:0] M_div_remainder;
    logic        M_div_by_zero;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t last_res = '0;
    int   n_total = 0;
    int   n_bad = 0;
    int   n_done = 0;

    nios_niosii_cpu_div_cell dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .E_src1          (E_src1),
        .E_src2          (E_src2),
        .E_div_start     (E_div_start),
        .E_div_signed    (E_div_signed),
        .M_div_abort     (M_div_abort),
        .M_div_busy      (M_div_busy),
        .M_div_done      (M_div_done),
        .M_div_quotient  (M_div_quotient),
        .M_div_remainder (M_div_remainder),
        .M_div_by_zero   (M_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        exp_t e;
        e.dz = 1'b0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b, input logic sgn);
`ifdef NIOS_DIV_FAST_EXIT_EN
        logic [31:0] m1, m2;
        m1 = (sgn && a[31]) ? -a : a;
        m2 = (sgn && b[31]) ? -b : b;
        if (b == 32'd0 || m1 < m2) return 2;
`endif
        return 34;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (M_div_done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", M_div_quotient, e.q);
                check("remainder", M_div_remainder, e.r);
                check("by_zero", 32'(M_div_by_zero), 32'(e.dz));
            end
        end
    end

    // Called just after a rising edge; that cycle is cycle 0. Optionally
    // re-asserts start with other operands in cycle restart_cyc.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input string tag, input int restart_cyc);
        exp_t e;
        int   lat, cyc;
        bit   got;
        e   = model(a, b, sgn);
        lat = lat_of(a, b, sgn);
        E_src1 = a; E_src2 = b; E_div_signed = sgn; E_div_start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        E_div_start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            if (restart_cyc != 0 && cyc == restart_cyc) begin
                E_src1 = 32'd9; E_src2 = 32'd3; E_div_start = 1'b1;
            end else begin
                E_div_start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1) check({tag, "_busy_c1"}, 32'(M_div_busy), 32'd1);
            if (M_div_done) begin
                got = 1'b1;
                check({tag, "_busy_done"}, 32'(M_div_busy), 32'd1);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        E_div_start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        if (!got) sb.delete();
        last_res = e;
        @(posedge clk); #1;
        check({tag, "_busy_after"}, 32'(M_div_busy), 32'd0);
        check({tag, "_done_after"}, 32'(M_div_done), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_snap;
        logic [31:0] a, b;
        logic        s;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(M_div_busy), 32'd0);
        check("rst_done", 32'(M_div_done), 32'd0);
        check("rst_quot", M_div_quotient, 32'd0);
        check("rst_rem", M_div_remainder, 32'd0);
        check("rst_dz", 32'(M_div_by_zero), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_div(32'd100, 32'd7, 1'b0, "divu_100_7", 0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2", 0);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2", 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf", 0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1", 0);
        do_div(32'd5, 32'd0, 1'b0, "divu_5_0", 0);
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1, "div_m5_0", 0);
        do_div(32'd3, 32'd10, 1'b0, "divu_3_10", 0);
        do_div(32'h8000_0000, 32'd3, 1'b1, "div_min_3", 0);

        // Start re-asserted while busy must be ignored
        do_div(32'd1000, 32'd33, 1'b0, "restart_busy", 5);

        // Abort in cycle 10; busy drops in cycle 11, results held, new start in cycle 11
        done_snap = n_done;
        E_src1 = 32'd500; E_src2 = 32'd9; E_div_signed = 1'b0; E_div_start = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        M_div_abort = 1'b1;
        @(negedge clk);
        check("abort_no_done_c10", 32'(M_div_done), 32'd0);
        @(posedge clk); #1;
        M_div_abort = 1'b0;
        check("abort_busy_c11", 32'(M_div_busy), 32'd0);
        check("abort_quot_held", M_div_quotient, last_res.q);
        check("abort_rem_held", M_div_remainder, last_res.r);
        check("abort_no_done", 32'(n_done), 32'(done_snap));
        do_div(32'd77, 32'd5, 1'b0, "after_abort", 0);

        // Reset in cycle 20 of an operation clears outputs at once
        E_src1 = 32'd12345; E_src2 = 32'd11; E_div_signed = 1'b0; E_div_start = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        done_snap = n_done;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(M_div_busy), 32'd0);
        check("mid_rst_quot", M_div_quotient, 32'd0);
        check("mid_rst_rem", M_div_remainder, 32'd0);
        check("mid_rst_dz", 32'(M_div_by_zero), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        check("mid_rst_no_done", 32'(n_done), 32'(done_snap));
        check("mid_rst_idle", 32'(M_div_busy), 32'd0);

        // Random operands, mixed signedness, with small divisors likely
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 3 == 0) b = -b;
            s = 1'($urandom_range(0, 1));
            do_div(a, b, s, "random", 0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
